// File: rtl/bfp_comp_prb_pack_if.sv
// Stream bundle between the sample source, the PRB compressor/packer and the
// downstream compression gearbox. The compressor connects through the slave
// modport; the producer/consumer side uses master.
interface bfp_comp_prb_pack_if;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [3:0]  ud_iq_width;
    logic [63:0] dout_data;
    logic [2:0]  dout_state;
    logic        dout_valid;
    logic        dout_sync;
    logic        dout_last;
    logic        err_tlast;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, ud_iq_width,
        input  s_axis_tready, dout_data, dout_state, dout_valid, dout_sync,
               dout_last, err_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, ud_iq_width,
        output s_axis_tready, dout_data, dout_state, dout_valid, dout_sync,
               dout_last, err_tlast
    );
endinterface

// File: rtl/bfp_comp_prb_pack.sv
// Per-PRB block-floating-point compressor and packer. Two PRB buffers are
// used ping-pong: one fills from the input stream while the other is shifted
// by its shared exponent, truncated to W bits and emitted as six MSB-aligned
// beats (beat 0 carries the udCompParam byte).
module bfp_comp_prb_pack #(
    parameter int NUM_BEATS = 6,
    parameter int SAMPLE_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    bfp_comp_prb_pack_if.slave bus
);
    localparam int BW = 3;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

    // Minimal two's complement width that holds x (1..16).
    function automatic logic [4:0] req_width(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] y;
        logic [4:0]          n;
        y = x[SAMPLE_W-1] ? ~x : x;
        n = 5'd1;
        for (int i = 0; i < SAMPLE_W - 1; i++)
            if (y[i]) n = 5'(i + 2);
        return n;
    endfunction

    // Shift four samples by e, keep W bits each, and MSB-align the fields;
    // on beat 0 the fields sit below the {4'b0, e} header byte.
    function automatic logic [63:0] pack(input logic [63:0] raw, input logic [3:0] e,
                                         input logic [3:0] w, input logic first);
        logic [63:0]                fields;
        logic [15:0]                mask;
        logic signed [SAMPLE_W-1:0] c;
        fields = '0;
        mask   = 16'((17'd1 << w) - 17'd1);
        for (int i = 0; i < 4; i++) begin
            c      = $signed(raw[i*SAMPLE_W +: SAMPLE_W]) >>> e;
            fields = (fields << w) | {48'b0, c & mask};
        end
        fields = fields << (7'd64 - {1'b0, w, 2'b00});
        return first ? {4'b0000, e, fields[63:8]} : fields;
    endfunction

    // Buffer contents and per-buffer PRB metadata
    logic [63:0]   buf_data [2][NUM_BEATS];
    logic [3:0]    buf_e    [2];
    logic [3:0]    buf_w    [2];
    logic [BW-1:0] buf_nb   [2];
    logic          buf_last [2];
    logic [1:0]    full;

    // Write side
    logic          wr_sel;
    logic [BW-1:0] wr_beat;
    logic [4:0]    run_n;
    logic [3:0]    cur_w;
    logic          rdy_en;
    logic          err_p;

    // Read side
    rd_state_t     rd_state;
    logic          rd_sel;
    logic [BW-1:0] rd_beat;
    logic          in_pkt;

    logic          hs, close, rd_free, rd_other;
    logic [4:0]    beat_n, n_acc;
    logic [3:0]    w_eff, e_new;
    logic [63:0]   rd_raw, rd_packed;

    assign hs       = bus.s_axis_tvalid && bus.s_axis_tready;
    assign close    = hs && (bus.s_axis_tlast || wr_beat == LAST_BEAT);
    assign rd_free  = (rd_state == RD_BUSY) && (rd_beat == LAST_BEAT);
    assign rd_other = ~rd_sel;
    // The buffer on its last output beat counts as free so a new PRB can start
    // filling it in the same cycle, keeping the input at full rate.
    assign bus.s_axis_tready = rdy_en && (!(full[0] && full[1]) || rd_free);

    assign n_acc = (wr_beat == '0 || beat_n > run_n) ? beat_n : run_n;
    assign w_eff = (wr_beat == '0) ? bus.ud_iq_width : cur_w;
    assign e_new = (n_acc > {1'b0, w_eff}) ? 4'(n_acc - {1'b0, w_eff}) : 4'd0;

    // Widest sample of the incoming beat
    always_comb begin
        // NOTE: every variable gets a value before any condition, so no latch is inferred.
        logic [4:0] n_i;
        n_i    = '0;
        beat_n = 5'd1;
        for (int i = 0; i < 4; i++) begin
            n_i = req_width(bus.s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]);
            if (n_i > beat_n) beat_n = n_i;
        end
    end

    // Beats past an early tlast read as zero samples
    always_comb begin
        rd_raw    = (rd_beat < buf_nb[rd_sel]) ? buf_data[rd_sel][rd_beat] : '0;
        rd_packed = pack(rd_raw, buf_e[rd_sel], buf_w[rd_sel], rd_beat == '0);
    end

    // Buffer storage and close-time metadata
    // NOTE: storage has no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (hs) buf_data[wr_sel][wr_beat] <= bus.s_axis_tdata;
        if (close) begin
            buf_e[wr_sel]    <= e_new;
            buf_w[wr_sel]    <= w_eff;
            buf_nb[wr_sel]   <= wr_beat + 3'd1;
            buf_last[wr_sel] <= bus.s_axis_tlast;
        end
    end

    // Write-side beat counter, running width max and early-tlast flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every block sees pre-edge values.
            wr_sel        <= 1'b0;
            wr_beat       <= '0;
            run_n         <= 5'd1;
            cur_w         <= '0;
            rdy_en        <= 1'b0;
            err_p         <= 1'b0;
            bus.err_tlast <= 1'b0;
        end else begin
            rdy_en        <= 1'b1;
            err_p         <= hs && bus.s_axis_tlast && (wr_beat != LAST_BEAT);
            bus.err_tlast <= err_p;
            if (hs) begin
                run_n <= n_acc;
                if (wr_beat == '0) cur_w <= bus.ud_iq_width;
                if (close) begin
                    wr_beat <= '0;
                    wr_sel  <= ~wr_sel;
                end else begin
                    wr_beat <= wr_beat + 3'd1;
                end
            end
        end
    end

    // Buffer occupancy: a buffer closing wins over one freeing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (rd_free) full[rd_sel] <= 1'b0;
            if (close)   full[wr_sel] <= 1'b1;
        end
    end

    // Read FSM: waits for a closed buffer, then emits its six beats back to back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state       <= RD_IDLE;
            rd_sel         <= 1'b0;
            rd_beat        <= '0;
            in_pkt         <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.dout_data  <= '0;
            bus.dout_state <= '0;
            bus.dout_sync  <= 1'b0;
            bus.dout_last  <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (full[rd_sel]) begin
                        rd_state <= RD_BUSY;
                        rd_beat  <= '0;
                    end
                end
                RD_BUSY: begin
                    bus.dout_valid <= 1'b1;
                    bus.dout_data  <= rd_packed;
                    bus.dout_state <= rd_beat;
                    bus.dout_last  <= rd_free && buf_last[rd_sel];
                    bus.dout_sync  <= in_pkt;
                    in_pkt         <= !(rd_free && buf_last[rd_sel]);
                    if (rd_free) begin
                        rd_sel  <= rd_other;
                        rd_beat <= '0;
                        if (!full[rd_other]) rd_state <= RD_IDLE;
                    end else begin
                        rd_beat <= rd_beat + 3'd1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bfp_comp_prb_pack.sv
// Directed scoreboard bench for bfp_comp_prb_pack: the driver pushes the
// hand-computed beats of each PRB when it closes, and a monitor pops and
// compares every beat the DUT presents, including its cycle of arrival.
module tb_bfp_comp_prb_pack;
    typedef struct {
        logic [63:0] data;
        logic [2:0]  state;
        logic        sync;
        logic        last;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bfp_comp_prb_pack_if bus ();
    bfp_comp_prb_pack dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t       sb[$];
    beat_t       mon_b;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          stalls = 0;
    int          err_cnt = 0;
    int          err_cyc = -1;
    logic [63:0] vin  [6];
    logic [63:0] vexp [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.dout_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_beat: got state=%0d data=%h want no beat", bus.dout_state, bus.dout_data);
            end else begin
                mon_b = sb.pop_front();
                check("dout_data",  bus.dout_data,        mon_b.data);
                check("dout_state", 64'(bus.dout_state),  64'(mon_b.state));
                check("dout_sync",  64'(bus.dout_sync),   64'(mon_b.sync));
                check("dout_last",  64'(bus.dout_last),   64'(mon_b.last));
                check("beat_cycle", 64'(cyc),             64'(mon_b.cyc));
            end
        end
    end

    // Early-tlast pulse recorder
    always @(negedge clk) begin
        if (!rst && bus.err_tlast) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [63:0] d, input logic l);
        int waited = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = l;
        while (!bus.s_axis_tready && waited < 100) begin
            waited++;
            stalls++;
            @(negedge clk);
        end
        if (!bus.s_axis_tready) begin
            total++;
            bad++;
            $display("FAIL tready_timeout: got 0 want 1");
        end
        @(posedge clk);
        #1 last_hs = cyc;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic push_prb(input logic tl, input logic sync0);
        beat_t b;
        for (int k = 0; k < 6; k++) begin
            b.data  = vexp[k];
            b.state = 3'(k);
            b.sync  = !(k == 0 && sync0);
            b.last  = tl && (k == 5);
            b.cyc   = last_hs + 2 + k;
            sb.push_back(b);
        end
    endtask

    task automatic run_prb(input int nb, input logic tl, input logic sync0);
        for (int k = 0; k < nb; k++) send_beat(vin[k], tl && (k == nb - 1));
        push_prb(tl, sync0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_vec();
        for (int k = 0; k < 6; k++) begin
            vin[k]  = '0;
            vexp[k] = '0;
        end
    endtask

    logic [15:0] sval [4] = '{16'h0100, 16'hFF80, 16'h1000, 16'h0003};
    logic [63:0] b0x  [4] = '{64'h0240_4040_4000_0000, 64'h0080_8080_8000_0000,
                              64'h0640_4040_4000_0000, 64'h0003_0303_0300_0000};
    logic [63:0] bnx  [4] = '{64'h4040_4040_0000_0000, 64'h8080_8080_0000_0000,
                              64'h4040_4040_0000_0000, 64'h0303_0303_0000_0000};

    initial begin
        int err0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.ud_iq_width   = 4'd9;

        // Reset state
        #1;
        check("rst_valid", 64'(bus.dout_valid),    64'd0);
        check("rst_data",  bus.dout_data,          64'd0);
        check("rst_sync",  64'(bus.dout_sync),     64'd0);
        check("rst_last",  64'(bus.dout_last),     64'd0);
        check("rst_err",   64'(bus.err_tlast),     64'd0);
        check("rst_ready", 64'(bus.s_axis_tready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_before_edge", 64'(bus.s_axis_tready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_edge", 64'(bus.s_axis_tready), 64'd1);
        @(negedge clk);

        // Single full-scale positive sample, W=9 -> e=7
        clear_vec();
        vin[0]  = 64'h0000_0000_0000_7FFF;
        vexp[0] = 64'h077F_8000_0000_0000;
        run_prb(6, 1'b1, 1'b1);
        idle();
        wait_drain();

        // Most negative sample in Q1 of beat 2 -> packs as 9'h100
        clear_vec();
        vin[2]  = 64'h8000_0000_0000_0000;
        vexp[0] = 64'h0700_0000_0000_0000;
        vexp[2] = 64'h0000_0010_0000_0000;
        run_prb(6, 1'b1, 1'b1);
        idle();
        wait_drain();

        // max |x| = 100 -> e=0; W changed mid-PRB must not take effect
        clear_vec();
        vin[0]  = 64'hFF9C_0064_0005_FFFF;
        vin[3]  = 64'hFF9C_0064_0005_FFFF;
        vexp[0] = 64'h00FF_814C_99C0_0000;
        vexp[3] = 64'hFF81_4C99_C000_0000;
        send_beat(vin[0], 1'b0);
        bus.ud_iq_width = 4'd4;
        for (int k = 1; k < 6; k++) send_beat(vin[k], k == 5);
        push_prb(1'b1, 1'b1);
        idle();
        wait_drain();

        // Four back-to-back PRBs at full rate, W=8, tlast on the fourth
        bus.ud_iq_width = 4'd8;
        stalls = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 6; k++) begin
                vin[k]  = {4{sval[p]}};
                vexp[k] = (k == 0) ? b0x[p] : bnx[p];
            end
            run_prb(6, p == 3, p == 0);
        end
        idle();
        check("b2b_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Early tlast on beat 2: zero-filled beats 3..5, last on beat 5
        clear_vec();
        for (int k = 0; k < 3; k++) vin[k] = {4{16'h0100}};
        vexp[0] = 64'h0240_4040_4000_0000;
        vexp[1] = 64'h4040_4040_0000_0000;
        vexp[2] = 64'h4040_4040_0000_0000;
        err0 = err_cnt;
        run_prb(3, 1'b1, 1'b1);
        idle();
        wait_drain();
        check("err_count", 64'(err_cnt - err0), 64'd1);
        check("err_cycle", 64'(err_cyc), 64'(last_hs + 1));

        // Burst after a gap, reset in the middle of the second PRB
        repeat (5) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            vin[k]  = {4{16'h0003}};
            vexp[k] = (k == 0) ? 64'h0003_0303_0300_0000 : 64'h0303_0303_0000_0000;
        end
        run_prb(6, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send_beat(vin[k], 1'b0);
        idle();
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", 64'(bus.dout_valid),    64'd0);
        check("mid_rst_data",  bus.dout_data,          64'd0);
        check("mid_rst_state", 64'(bus.dout_state),    64'd0);
        check("mid_rst_sync",  64'(bus.dout_sync),     64'd0);
        check("mid_rst_last",  64'(bus.dout_last),     64'd0);
        check("mid_rst_ready", 64'(bus.s_axis_tready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_rst_ready", 64'(bus.s_axis_tready), 64'd1);
        repeat (4) @(negedge clk);
        run_prb(6, 1'b1, 1'b1);
        idle();
        wait_drain();

        check("err_total", 64'(err_cnt), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bfp_comp_prb_pack.md
Name: bfp_comp_prb_pack

Overview:
Per-PRB block-floating-point compressor and packer. It sits directly upstream of the compression gearbox and produces that stage's din_data/din_state/din_valid/din_sync/din_last beats.
- Buffers one PRB: 12 subcarriers, 24 signed 16-bit samples, 6 input beats of 4 samples.
- Computes the shared exponent for the PRB.
- Arithmetic-shifts every sample down to ud_iq_width bits.
- Emits 6 MSB-aligned beats; beat 0 carries the udCompParam byte.
- Ping-pong buffering sustains one input beat per cycle.

Parameters:
NUM_BEATS, 6, input/output beats per PRB (fixed by O-RAN; not meant to be overridden)
SAMPLE_W, 16, input sample width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_tdata  in  64  {Q1,I1,Q0,I0}, I0 in [15:0], two's complement
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet; legal only on the 6th beat of a PRB
dout_data  out  64  packed beat, MSB-aligned, unused low bits zero
dout_state  out  3  beat index within PRB, 0..5
dout_valid  out  1  beat valid; no backpressure from the gearbox
dout_sync  out  1  0 on first beat of a packet, 1 otherwise
dout_last  out  1  last beat of packet
err_tlast  out  1  one-cycle pulse on early tlast
ud_iq_width  in  4  compressed width W, legal 1..15, quasi-static

Behaviour:
Reset
- All outputs 0, both buffers empty, beat counter 0.
- dout_sync is 0 for the first beat after reset.
- s_axis_tready is 1 from the first clock edge after rst deasserts.
- rst mid-PRB discards all buffered data; no partial output.

Input side
- Handshake is tvalid && tready.
- Beats fill the current write buffer, beat index 0..5.
- A running max of per-sample required width n(x) is kept, where n(x) is the minimal signed width holding x, range 1..16. Examples: n(0)=1, n(-1)=1, n(100)=8, n(0x7FFF)=16, n(-32768)=16.
- W is sampled on the PRB's beat-0 handshake and used for the whole PRB.
- Write buffer closes after the 6th beat.
- tready = 0 only while both buffers are full; it is combinational from buffer state and must not depend on tvalid.

Early tlast
- If tlast arrives on beat k<5, remaining samples are treated as zero and the PRB closes.
- err_tlast pulses 1 cycle after that handshake.
- The output marks this PRB's beat 5 as last.

Exponent
- N = max n(x) over 24 samples; e = max(0, N−W), 4 bits.
- Compressed sample c = x >>> e: arithmetic shift, truncation, no rounding, no saturation needed.
- Low W bits of c are kept.

Output side
- Latency: if the closing handshake is at cycle T, beat 0 has dout_valid=1 at T+2, and beats 1..5 follow at T+3..T+7 with no gaps.
- Next PRB's beat 0 may follow directly at T+8 if ready.
- Beat 0: [63:56] = {4'b0000, e}; then I0,Q0,I1,Q1 of W bits each starting at bit 55 downward.
- Beats 1..5: 4 samples occupying [63 -: 4W], same order.
- Bits below the packed field are 0.
- dout_state = beat index.
- dout_last = 1 on beat 5 of a PRB closed by tlast, including an early-tlast PRB; otherwise 0.
- dout_sync = 0 on the first beat after reset or after a beat with dout_last; 1 otherwise.
- When dout_valid=0, dout_data/state/last/sync hold their last values.
- Read buffer frees after beat 5 is emitted.
- Simultaneous events: closing one buffer while freeing the other in the same cycle is legal; tready stays 1.

W changes
- Changes only between packets; a mid-PRB change takes effect at the next beat 0.

Test Plan:
- Single PRB, W=9, I0=0x7FFF, others 0, tlast on beat 5 -> e=7; beat 0 dout_data=0x077F_8000_0000_0000 with state 0, sync 0; beats 1..5 all zero; beat 5 last=1; beat 0 at T+2.
- W=9, one sample −32768, rest 0 -> e=7; that sample packs as 9'h100; all other fields 0.
- W=9, max |x|=100 -> N=8, e=0; samples pass unshifted into 9-bit fields.
- 4 back-to-back PRBs, tvalid held 1, W=8, last on PRB 4 -> tready stays 1 throughout; 24 contiguous output beats; states 0..5 repeating; sync 0 only on very first beat; last only on beat 23.
- Output stalled by a full-rate burst after a gap, with reset asserted mid-PRB 2 -> all outputs 0 immediately; after release, next packet starts with sync 0 and no stale beats.
- tlast on beat 2 -> err_tlast pulse; 6 output beats emitted; beats 3..5 carry zero samples; beat 5 last=1.
